nand_target_array_emu: RTL and testbench

- Parametrised, synthesizable emulator for NUM_TARGETS NAND targets sharing one ONFI-style command/address/data bus.
- Decodes reset, read, program, erase and status commands per target, and runs a per-target busy timer that drives an individual rb_n.
- Returns deterministic read data and a sticky protocol-error flag.
- Sits under the flash-controller testbench and the on-board loopback build, replacing fixed-count chip models with any target count.

---
 rtl/nand_target_array_emu.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_nand_target_array_emu.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_target_array_emu.sv
// Emulates NUM_TARGETS NAND targets sharing one ONFI-style command/address/data bus.
// Each target runs its own command FSM and busy timer. Read data is deterministic
// (first column byte plus a running index) and any bus misuse raises a sticky error.
//
// Ports:
//   CLK          - single clock
//   RST_N        - synchronous active-low reset
//   cen          - active-low per-target chip enables
//   cle, ale     - command / address latch enables qualifying we_strobe
//   wpn          - active-low write protect
//   we_strobe    - one-cycle bus write of dq_in
//   dq_in        - bus write data
//   re_strobe    - one-cycle bus read request
//   dq_out       - read data, held between valid pulses
//   dq_out_valid - one-cycle pulse the cycle after an accepted re_strobe
//   rb_n         - per-target ready/busy, low while busy
//   err_protocol - sticky protocol error, cleared only by reset
`timescale 1ns/1ps
module nand_target_array_emu #(
    parameter int unsigned NUM_TARGETS = 8,
    parameter int unsigned DQ_W        = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned T_RST       = 8,
    parameter int unsigned T_READ      = 16,
    parameter int unsigned T_PROG      = 64,
    parameter int unsigned T_ERASE     = 256,
    parameter int unsigned ADDR_CYCLES = 5
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NUM_TARGETS-1:0] cen,
    input  logic                   cle,
    input  logic                   ale,
    input  logic                   wpn,
    input  logic                   we_strobe,
    input  logic [DQ_W-1:0]        dq_in,
    input  logic                   re_strobe,
    output logic [DQ_W-1:0]        dq_out,
    output logic                   dq_out_valid,
    output logic [NUM_TARGETS-1:0] rb_n,
    output logic                   err_protocol
);

    localparam int unsigned IdxW  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int unsigned SelW  = $clog2(NUM_TARGETS + 1);
    localparam int unsigned NeedW = $clog2(ADDR_CYCLES + 1);

    localparam logic [DQ_W-1:0] CmdReset   = DQ_W'(8'hFF);
    localparam logic [DQ_W-1:0] CmdStatus  = DQ_W'(8'h70);
    localparam logic [DQ_W-1:0] CmdRead    = DQ_W'(8'h00);
    localparam logic [DQ_W-1:0] CmdReadGo  = DQ_W'(8'h30);
    localparam logic [DQ_W-1:0] CmdProg    = DQ_W'(8'h80);
    localparam logic [DQ_W-1:0] CmdProgGo  = DQ_W'(8'h10);
    localparam logic [DQ_W-1:0] CmdErase   = DQ_W'(8'h60);
    localparam logic [DQ_W-1:0] CmdEraseGo = DQ_W'(8'hD0);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StConfirm,
        StProgData,
        StBusy,
        StDout
    } state_e;

    typedef enum logic [1:0] {
        OpRead,
        OpProg,
        OpErase
    } op_e;

    // Per-target state
    state_e           state_q     [NUM_TARGETS];
    state_e           exit_q      [NUM_TARGETS];  // state entered when the busy timer expires
    op_e              op_q        [NUM_TARGETS];
    logic [CNT_W-1:0] timer_q     [NUM_TARGETS];
    logic [NeedW-1:0] need_q      [NUM_TARGETS];
    logic [DQ_W-1:0]  col0_q      [NUM_TARGETS];
    logic             col0_pend_q [NUM_TARGETS];  // next address byte is the first one
    logic [DQ_W-1:0]  idx_q       [NUM_TARGETS];
    logic             status_q    [NUM_TARGETS];
    logic             fail_q      [NUM_TARGETS];

    logic [DQ_W-1:0]  dq_out_q;
    logic             dq_out_valid_q;
    logic             err_q;

    // Bus decode
    logic [SelW-1:0]  sel_cnt;
    logic [IdxW-1:0]  sel_idx;
    logic             one_sel;
    logic             wr_ok;
    logic             rd_ok;
    logic             strobe_err;
    logic             is_cmd;
    logic             is_addr;
    logic             is_data;
    state_e           sel_state;
    op_e              sel_op;
    logic [NeedW-1:0] sel_need;
    logic             sel_pend;
    logic [DQ_W-1:0]  status_byte;
    logic [DQ_W-1:0]  dout_byte;

    always_comb begin
        sel_cnt = '0;
        sel_idx = '0;
        for (int t = 0; t < NUM_TARGETS; t++) begin
            if (!cen[t]) begin
                sel_cnt = sel_cnt + SelW'(1);
                sel_idx = IdxW'(t);
            end
        end
    end

    always_comb begin
        one_sel    = (sel_cnt == SelW'(1));
        wr_ok      = we_strobe && !re_strobe && one_sel;
        rd_ok      = re_strobe && !we_strobe && one_sel;
        // Simultaneous strobes are an error even with nothing selected.
        strobe_err = (we_strobe && re_strobe) ||
                     ((we_strobe || re_strobe) && (sel_cnt > SelW'(1)));
        is_cmd     = cle && !ale;
        is_addr    = ale && !cle;
        is_data    = !cle && !ale;
    end

    always_comb begin
        sel_state   = state_q[sel_idx];
        sel_op      = op_q[sel_idx];
        sel_need    = need_q[sel_idx];
        sel_pend    = col0_pend_q[sel_idx];
        dout_byte   = col0_q[sel_idx] + idx_q[sel_idx];
        status_byte = '0;
        status_byte[DQ_W-1] = wpn;
        status_byte[DQ_W-2] = (state_q[sel_idx] != StBusy);
        status_byte[0]      = fail_q[sel_idx];
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int t = 0; t < NUM_TARGETS; t++) begin
                state_q[t]     <= StIdle;
                exit_q[t]      <= StIdle;
                op_q[t]        <= OpRead;
                timer_q[t]     <= '0;
                need_q[t]      <= '0;
                col0_q[t]      <= '0;
                col0_pend_q[t] <= 1'b0;
                idx_q[t]       <= '0;
                status_q[t]    <= 1'b0;
                fail_q[t]      <= 1'b0;
            end
            dq_out_q       <= '0;
            dq_out_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            dq_out_valid_q <= 1'b0;

            // Busy timers run independently; a bus write below may override the selected one.
            for (int t = 0; t < NUM_TARGETS; t++) begin
                if (state_q[t] == StBusy) begin
                    if (timer_q[t] <= CNT_W'(1)) begin
                        state_q[t] <= exit_q[t];
                        timer_q[t] <= '0;
                    end else begin
                        timer_q[t] <= timer_q[t] - CNT_W'(1);
                    end
                end
            end

            if (strobe_err) begin
                err_q <= 1'b1;
            end

            if (wr_ok) begin
                if (cle && ale) begin
                    err_q <= 1'b1;
                end else if (is_cmd && dq_in == CmdReset) begin
                    state_q[sel_idx]  <= StBusy;
                    timer_q[sel_idx]  <= CNT_W'(T_RST);
                    exit_q[sel_idx]   <= StIdle;
                    status_q[sel_idx] <= 1'b0;
                    fail_q[sel_idx]   <= 1'b0;
                end else if (is_cmd && dq_in == CmdStatus) begin
                    status_q[sel_idx] <= 1'b1;
                end else if (sel_state == StBusy) begin
                    // Busy targets ignore everything but reset and status.
                    err_q <= 1'b1;
                end else if (is_cmd) begin
                    if ((sel_state == StIdle || sel_state == StDout) && dq_in == CmdRead) begin
                        state_q[sel_idx]     <= StAddr;
                        op_q[sel_idx]        <= OpRead;
                        need_q[sel_idx]      <= NeedW'(ADDR_CYCLES);
                        col0_pend_q[sel_idx] <= 1'b1;
                        status_q[sel_idx]    <= 1'b0;
                    end else if ((sel_state == StIdle || sel_state == StDout) &&
                                 dq_in == CmdProg) begin
                        state_q[sel_idx]     <= StAddr;
                        op_q[sel_idx]        <= OpProg;
                        need_q[sel_idx]      <= NeedW'(ADDR_CYCLES);
                        col0_pend_q[sel_idx] <= 1'b1;
                    end else if ((sel_state == StIdle || sel_state == StDout) &&
                                 dq_in == CmdErase) begin
                        state_q[sel_idx]     <= StAddr;
                        op_q[sel_idx]        <= OpErase;
                        need_q[sel_idx]      <= NeedW'(ADDR_CYCLES - 2);
                        col0_pend_q[sel_idx] <= 1'b1;
                    end else if (sel_state == StConfirm && sel_op == OpRead &&
                                 dq_in == CmdReadGo) begin
                        state_q[sel_idx] <= StBusy;
                        timer_q[sel_idx] <= CNT_W'(T_READ);
                        exit_q[sel_idx]  <= StDout;
                        idx_q[sel_idx]   <= '0;
                    end else if ((sel_state == StProgData && dq_in == CmdProgGo) ||
                                 (sel_state == StConfirm && sel_op == OpErase &&
                                  dq_in == CmdEraseGo)) begin
                        if (wpn) begin
                            state_q[sel_idx] <= StBusy;
                            timer_q[sel_idx] <= (sel_state == StProgData) ?
                                                CNT_W'(T_PROG) : CNT_W'(T_ERASE);
                            exit_q[sel_idx]  <= StIdle;
                        end else begin
                            // Write-protected: report failure without going busy.
                            state_q[sel_idx] <= StIdle;
                            fail_q[sel_idx]  <= 1'b1;
                        end
                    end else begin
                        state_q[sel_idx] <= StIdle;
                        err_q            <= 1'b1;
                    end
                end else if (is_addr) begin
                    if (sel_state == StAddr) begin
                        need_q[sel_idx] <= sel_need - NeedW'(1);
                        if (sel_pend) begin
                            col0_q[sel_idx]      <= dq_in;
                            col0_pend_q[sel_idx] <= 1'b0;
                        end
                        if (sel_need <= NeedW'(1)) begin
                            state_q[sel_idx] <= (sel_op == OpProg) ? StProgData : StConfirm;
                        end
                    end else begin
                        state_q[sel_idx] <= StIdle;
                        err_q            <= 1'b1;
                    end
                end else if (is_data) begin
                    // Program data is accepted and discarded.
                    if (sel_state != StProgData) begin
                        state_q[sel_idx] <= StIdle;
                        err_q            <= 1'b1;
                    end
                end
            end

            if (rd_ok) begin
                dq_out_valid_q <= 1'b1;
                if (status_q[sel_idx]) begin
                    dq_out_q <= status_byte;
                end else if (sel_state == StDout) begin
                    dq_out_q       <= dout_byte;
                    idx_q[sel_idx] <= idx_q[sel_idx] + DQ_W'(1);
                end else begin
                    dq_out_q <= '0;
                    err_q    <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NUM_TARGETS; t++) begin
            rb_n[t] = (state_q[t] != StBusy);
        end
    end

    assign dq_out       = dq_out_q;
    assign dq_out_valid = dq_out_valid_q;
    assign err_protocol = err_q;

endmodule

// File: tb/tb_nand_target_array_emu.sv
`timescale 1ns/1ps
module tb_nand_target_array_emu;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] cen;
    logic       cle;
    logic       ale;
    logic       wpn;
    logic       we_strobe;
    logic [7:0] dq_in;
    logic       re_strobe;
    logic [7:0] dq_out;
    logic       dq_out_valid;
    logic [7:0] rb_n;
    logic       err_protocol;

    int n_cmp  = 0;
    int n_fail = 0;
    int low_cnt [8] = '{8{0}};

    nand_target_array_emu dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .cen          (cen),
        .cle          (cle),
        .ale          (ale),
        .wpn          (wpn),
        .we_strobe    (we_strobe),
        .dq_in        (dq_in),
        .re_strobe    (re_strobe),
        .dq_out       (dq_out),
        .dq_out_valid (dq_out_valid),
        .rb_n         (rb_n),
        .err_protocol (err_protocol)
    );

    always #5 CLK = ~CLK;

    // Busy-cycle accounting per target, sampled mid-cycle.
    always @(negedge CLK) begin
        for (int t = 0; t < 8; t++) begin
            if (rb_n[t] === 1'b0) low_cnt[t]++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] c, input logic l_cle, input logic l_ale,
                      input logic [7:0] d);
        cen       = c;
        cle       = l_cle;
        ale       = l_ale;
        dq_in     = d;
        we_strobe = 1'b1;
        tick();
        we_strobe = 1'b0;
        cle       = 1'b0;
        ale       = 1'b0;
        cen       = 8'hFF;
    endtask

    task automatic cmd(input logic [7:0] c, input logic [7:0] d);
        wr(c, 1'b1, 1'b0, d);
    endtask

    task automatic adr(input logic [7:0] c, input logic [7:0] d);
        wr(c, 1'b0, 1'b1, d);
    endtask

    task automatic rd(input logic [7:0] c);
        cen       = c;
        re_strobe = 1'b1;
        tick();
        re_strobe = 1'b0;
        cen       = 8'hFF;
    endtask

    task automatic wait_ready(input int t, input int max);
        int n;
        n = 0;
        while (rb_n[t] !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        n_cmp++;
        if (rb_n[t] !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_ready_%0d: rb_n=%b still busy after %0d cycles", t, rb_n, max);
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (rb_n !== 8'hFF) begin
            n_fail++; $display("FAIL reset_rb_n: got %h want ff", rb_n);
        end
        n_cmp++;
        if (dq_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_dq_out: got %h want 00", dq_out);
        end
        n_cmp++;
        if (dq_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", dq_out_valid);
        end
        n_cmp++;
        if (err_protocol !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", err_protocol);
        end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_read();
        int base;
        logic [7:0] exp_dq [3];
        exp_dq[0] = 8'hFE;
        exp_dq[1] = 8'hFF;
        exp_dq[2] = 8'h00;
        base = low_cnt[3];
        cmd(8'hF7, 8'h00);
        adr(8'hF7, 8'hFE);
        for (int i = 1; i < 5; i++) adr(8'hF7, 8'(i));
        cmd(8'hF7, 8'h30);
        n_cmp++;
        if (rb_n !== 8'hF7) begin
            n_fail++; $display("FAIL read_busy_start: rb_n=%h want f7", rb_n);
        end
        wait_ready(3, 40);
        n_cmp++;
        if (low_cnt[3] - base !== 16) begin
            n_fail++; $display("FAIL read_busy_len: got %0d want 16", low_cnt[3] - base);
        end
        for (int i = 0; i < 3; i++) begin
            rd(8'hF7);
            n_cmp++;
            if (dq_out_valid !== 1'b1 || dq_out !== exp_dq[i]) begin
                n_fail++;
                $display("FAIL read_data_%0d: valid=%b dq=%h want valid=1 dq=%h",
                         i, dq_out_valid, dq_out, exp_dq[i]);
            end
            tick();
            n_cmp++;
            if (dq_out_valid !== 1'b0 || dq_out !== exp_dq[i]) begin
                n_fail++;
                $display("FAIL read_hold_%0d: valid=%b dq=%h want valid=0 dq=%h",
                         i, dq_out_valid, dq_out, exp_dq[i]);
            end
        end
        n_cmp++;
        if (err_protocol !== 1'b0) begin
            n_fail++; $display("FAIL read_err: got %b want 0", err_protocol);
        end
    endtask

    task automatic test_overlap();
        int b0;
        int b7;
        b0 = low_cnt[0];
        b7 = low_cnt[7];
        cmd(8'hFE, 8'h60);
        for (int i = 0; i < 3; i++) adr(8'hFE, 8'(8'h20 + i));
        cmd(8'hFE, 8'hD0);
        tick();
        tick();
        cmd(8'h7F, 8'h80);
        for (int i = 0; i < 5; i++) adr(8'h7F, 8'(8'h40 + i));
        wr(8'h7F, 1'b0, 1'b0, 8'hAA);
        cmd(8'h7F, 8'h10);
        n_cmp++;
        if (rb_n !== 8'h7E) begin
            n_fail++; $display("FAIL overlap_both_busy: rb_n=%h want 7e", rb_n);
        end
        cmd(8'hFE, 8'h70);
        rd(8'hFE);
        n_cmp++;
        if (dq_out_valid !== 1'b1 || dq_out !== 8'h80) begin
            n_fail++;
            $display("FAIL overlap_status: valid=%b dq=%h want valid=1 dq=80",
                     dq_out_valid, dq_out);
        end
        wait_ready(7, 100);
        wait_ready(0, 300);
        n_cmp++;
        if (low_cnt[0] - b0 !== 256) begin
            n_fail++; $display("FAIL erase_busy_len: got %0d want 256", low_cnt[0] - b0);
        end
        n_cmp++;
        if (low_cnt[7] - b7 !== 64) begin
            n_fail++; $display("FAIL prog_busy_len: got %0d want 64", low_cnt[7] - b7);
        end
        n_cmp++;
        if (err_protocol !== 1'b0) begin
            n_fail++; $display("FAIL overlap_err: got %b want 0", err_protocol);
        end
    endtask

    task automatic test_write_protect();
        int b1;
        b1  = low_cnt[1];
        wpn = 1'b0;
        cmd(8'hFD, 8'h80);
        for (int i = 0; i < 5; i++) adr(8'hFD, 8'(i));
        wr(8'hFD, 1'b0, 1'b0, 8'h55);
        cmd(8'hFD, 8'h10);
        n_cmp++;
        if (rb_n !== 8'hFF) begin
            n_fail++; $display("FAIL wp_no_busy: rb_n=%h want ff", rb_n);
        end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (low_cnt[1] - b1 !== 0) begin
            n_fail++; $display("FAIL wp_busy_len: got %0d want 0", low_cnt[1] - b1);
        end
        cmd(8'hFD, 8'h70);
        rd(8'hFD);
        n_cmp++;
        if (dq_out_valid !== 1'b1 || dq_out !== 8'h41) begin
            n_fail++;
            $display("FAIL wp_status: valid=%b dq=%h want valid=1 dq=41", dq_out_valid, dq_out);
        end
        n_cmp++;
        if (err_protocol !== 1'b0) begin
            n_fail++; $display("FAIL wp_err: got %b want 0", err_protocol);
        end
        wpn = 1'b1;
    endtask

    task automatic test_reset_busy();
        int b2;
        int b4;
        cmd(8'hFB, 8'h60);
        for (int i = 0; i < 3; i++) adr(8'hFB, 8'(i));
        cmd(8'hFB, 8'hD0);
        for (int i = 0; i < 10; i++) tick();
        cmd(8'hFB, 8'h00);
        n_cmp++;
        if (err_protocol !== 1'b1 || rb_n[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_cmd_err: err=%b rb_n=%h want err=1 rb_n[2]=0",
                     err_protocol, rb_n);
        end
        for (int i = 0; i < 18; i++) tick();
        cmd(8'hFB, 8'hFF);
        b2 = low_cnt[2];
        n_cmp++;
        if (rb_n[2] !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy_start: rb_n=%h want bit2 low", rb_n);
        end
        wait_ready(2, 30);
        n_cmp++;
        if (low_cnt[2] - b2 !== 8) begin
            n_fail++; $display("FAIL rst_busy_len: got %0d want 8", low_cnt[2] - b2);
        end
        // A write to a busy read target must leave it heading for data out.
        b4 = low_cnt[4];
        cmd(8'hEF, 8'h00);
        adr(8'hEF, 8'h10);
        for (int i = 1; i < 5; i++) adr(8'hEF, 8'h00);
        cmd(8'hEF, 8'h30);
        tick();
        cmd(8'hEF, 8'h00);
        wait_ready(4, 40);
        n_cmp++;
        if (low_cnt[4] - b4 !== 16) begin
            n_fail++; $display("FAIL busy_ignore_len: got %0d want 16", low_cnt[4] - b4);
        end
        rd(8'hEF);
        n_cmp++;
        if (dq_out_valid !== 1'b1 || dq_out !== 8'h10) begin
            n_fail++;
            $display("FAIL busy_ignore_data: valid=%b dq=%h want valid=1 dq=10",
                     dq_out_valid, dq_out);
        end
    endtask

    task automatic test_multi_select();
        do_reset();
        cmd(8'hFF, 8'h00);
        n_cmp++;
        if (err_protocol !== 1'b0) begin
            n_fail++; $display("FAIL zero_sel_err: got %b want 0", err_protocol);
        end
        cmd(8'hFC, 8'h00);
        n_cmp++;
        if (err_protocol !== 1'b1) begin
            n_fail++; $display("FAIL multi_sel_err: got %b want 1", err_protocol);
        end
        // Target 0 must still be idle, so this read sequence must not start.
        for (int i = 0; i < 5; i++) adr(8'hFE, 8'(i));
        cmd(8'hFE, 8'h30);
        tick();
        n_cmp++;
        if (rb_n !== 8'hFF) begin
            n_fail++; $display("FAIL multi_sel_no_change: rb_n=%h want ff", rb_n);
        end
        do_reset();
        n_cmp++;
        if (err_protocol !== 1'b0) begin
            n_fail++; $display("FAIL rerst_err: got %b want 0", err_protocol);
        end
        cmd(8'hDF, 8'h80);
        for (int i = 0; i < 5; i++) adr(8'hDF, 8'(i));
        cmd(8'hDF, 8'h10);
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (rb_n !== 8'hDF) begin
            n_fail++; $display("FAIL prog_mid: rb_n=%h want df", rb_n);
        end
        RST_N = 1'b0;
        tick();
        n_cmp++;
        if (rb_n !== 8'hFF) begin
            n_fail++; $display("FAIL rst_mid_prog: rb_n=%h want ff", rb_n);
        end
        RST_N = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (rb_n !== 8'hFF) begin
            n_fail++; $display("FAIL rst_mid_prog_after: rb_n=%h want ff", rb_n);
        end
    endtask

    initial begin
        RST_N     = 1'b0;
        cen       = 8'hFF;
        cle       = 1'b0;
        ale       = 1'b0;
        wpn       = 1'b1;
        we_strobe = 1'b0;
        dq_in     = 8'h00;
        re_strobe = 1'b0;
        test_reset();
        test_read();
        test_overlap();
        test_write_protect();
        test_reset_busy();
        test_multi_select();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
